// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM state type for the boot-time program loader.
package prog_loader_pkg;

   localparam int PM_DEPTH  = 32;
   localparam int PM_ADDR_W = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      HI    = 3'd2,
      LO    = 3'd3,
      WRITE = 3'd4,
      CSUM  = 3'd5,
      DONE  = 3'd6,
      ERR   = 3'd7
   } loader_state;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian words, writes program memory,
// verifies an XOR checksum and only then releases the CPU clock enable.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int PM_ADDR_W = 5,
   parameter int PM_DEPTH  = 32,
   parameter int INSTR_W   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_valid,
   input  logic [7:0]           i_byte,
   output logic                 o_ready,
   output logic                 o_pm_we,
   output logic [PM_ADDR_W-1:0] o_pm_addr,
   output logic [INSTR_W-1:0]   o_pm_data,
   output logic                 o_cpu_ce,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   output logic [PM_ADDR_W:0]   o_word_count
);

   loader_state          state_q, state_d;
   logic [PM_ADDR_W:0]   len_q;
   logic [7:0]           csum_q;
   logic                 accept;
   logic                 start_ok;
   logic                 len_bad;
   logic                 last_word;

   assign accept    = i_valid & o_ready;
   assign start_ok  = i_start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
   assign len_bad   = (i_byte == 8'd0) || (int'(i_byte) > PM_DEPTH);
   assign last_word = ({1'b0, o_pm_addr} == (len_q - (PM_ADDR_W + 1)'(1)));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: if (i_start) state_d = LEN;
         LEN:   if (accept) state_d = len_bad ? ERR : HI;
         HI:    if (accept) state_d = LO;
         LO:    if (accept) state_d = WRITE;
         WRITE: state_d = last_word ? CSUM : HI;
         CSUM:  if (accept) state_d = (i_byte == csum_q) ? DONE : ERR;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs are registered decodes of the next state, so they change
   // on the same edge as the state itself and never depend on i_valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         csum_q       <= 8'd0;
         o_ready      <= 1'b0;
         o_pm_we      <= 1'b0;
         o_pm_addr    <= '0;
         o_pm_data    <= '0;
         o_cpu_ce     <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_word_count <= '0;
      end else begin
         state_q  <= state_d;
         o_ready  <= (state_d == LEN) | (state_d == HI) | (state_d == LO) | (state_d == CSUM);
         o_pm_we  <= (state_d == WRITE);
         o_busy   <= (state_d == LEN) | (state_d == HI) | (state_d == LO) |
                     (state_d == WRITE) | (state_d == CSUM);
         o_done   <= (state_d == DONE);
         o_err    <= (state_d == ERR);
         o_cpu_ce <= (state_d == DONE);

         if (start_ok) begin
            csum_q       <= 8'd0;
            o_word_count <= '0;
         end

         case (state_q)
            LEN: begin
               if (accept && !len_bad) begin
                  len_q     <= i_byte[PM_ADDR_W:0];
                  csum_q    <= csum_q ^ i_byte;
                  o_pm_addr <= '0;
               end
            end
            HI: begin
               if (accept) begin
                  o_pm_data[INSTR_W-1 -: 8] <= i_byte;
                  csum_q                    <= csum_q ^ i_byte;
               end
            end
            LO: begin
               if (accept) begin
                  o_pm_data[7:0] <= i_byte;
                  csum_q         <= csum_q ^ i_byte;
               end
            end
            WRITE: begin
               o_word_count <= o_word_count + (PM_ADDR_W + 1)'(1);
               if (!last_word) o_pm_addr <= o_pm_addr + PM_ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: expected writes and load outcomes
// are queued by the driver and checked by an independent output monitor.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        valid;
   logic [7:0]  bytev;
   logic        ready;
   logic        pm_we;
   logic [4:0]  pm_addr;
   logic [15:0] pm_data;
   logic        cpu_ce;
   logic        busy;
   logic        done;
   logic        err;
   logic [5:0]  wc;

   prog_loader #(
      .PM_ADDR_W (5),
      .PM_DEPTH  (32),
      .INSTR_W   (16)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_valid      (valid),
      .i_byte       (bytev),
      .o_ready      (ready),
      .o_pm_we      (pm_we),
      .o_pm_addr    (pm_addr),
      .o_pm_data    (pm_data),
      .o_cpu_ce     (cpu_ce),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_word_count (wc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic       ok;
      logic       bad;
      logic [5:0] words;
   } end_t;

   wr_t         exp_wr[$];
   end_t        exp_end[$];
   logic [7:0]  byte_q[$];
   logic [15:0] ref_mem[32];
   logic [15:0] dut_mem[32];
   int          checks = 0;
   int          passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: compares every write strobe and every end of load against the queues.
   logic busy_prev = 1'b0;
   wr_t  mon_w;
   end_t mon_e;
   always @(negedge clk) begin
      if (pm_we === 1'b1) begin
         dut_mem[pm_addr] = pm_data;
         check("ready_low_in_write", {31'd0, ready}, 32'd0);
         check("write_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
         if (exp_wr.size() > 0) begin
            mon_w = exp_wr.pop_front();
            check("wr_addr", {27'd0, pm_addr}, {27'd0, mon_w.addr});
            check("wr_data", {16'd0, pm_data}, {16'd0, mon_w.data});
         end
      end
      if (busy_prev && busy === 1'b0) begin
         check("end_expected", {31'd0, exp_end.size() > 0}, 32'd1);
         if (exp_end.size() > 0) begin
            mon_e = exp_end.pop_front();
            check("end_done", {31'd0, done}, {31'd0, mon_e.ok});
            check("end_err", {31'd0, err}, {31'd0, mon_e.bad});
            check("end_cpu_ce", {31'd0, cpu_ce}, {31'd0, mon_e.ok});
            check("end_word_count", {26'd0, wc}, {26'd0, mon_e.words});
         end
      end
      busy_prev = (busy === 1'b1);
   end

   // Reference model: derive expected writes and outcome straight from the image bytes.
   task automatic model_push();
      int         n;
      logic [7:0] x;
      end_t       e;
      n = int'(byte_q[0]);
      if (n == 0 || n > 32) begin
         e = '{ok: 1'b0, bad: 1'b1, words: 6'd0};
      end else begin
         x = 8'd0;
         for (int i = 0; i <= 2 * n; i++) x = x ^ byte_q[i];
         for (int i = 0; i < n; i++) begin
            exp_wr.push_back('{addr: 5'(i), data: {byte_q[1 + 2 * i], byte_q[2 + 2 * i]}});
            ref_mem[i] = {byte_q[1 + 2 * i], byte_q[2 + 2 * i]};
         end
         e.ok    = (x == byte_q[2 * n + 1]);
         e.bad   = !e.ok;
         e.words = 6'(n);
      end
      exp_end.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("after_start", {26'd0, ready, cpu_ce, busy, done, err, wc}, {26'd0, 5'b10100, 6'd0});
   endtask

   task automatic send(input logic [7:0] b, input bit gaps, input bit stray);
      bit accepted;
      accepted = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
         valid = 1'b0;
         bytev = 8'($urandom);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      valid = 1'b1;
      bytev = b;
      start = stray;
      for (int t = 0; t < 50; t++) begin
         if (ready) begin
            @(negedge clk);
            accepted = 1'b1;
            break;
         end
         @(negedge clk);
         start = 1'b0;
      end
      start = 1'b0;
      check("byte_accepted", {31'd0, accepted}, 32'd1);
   endtask

   task automatic run_load(input bit gaps, input bit stray);
      int n;
      int nbytes;
      n = int'(byte_q[0]);
      model_push();
      nbytes = (n == 0 || n > 32) ? 1 : 2 * n + 2;
      pulse_start();
      for (int i = 0; i < nbytes; i++) send(byte_q[i], gaps, stray && (i == nbytes / 2));
      valid = 1'b0;
      for (int t = 0; t < 20 && busy; t++) @(negedge clk);
      check("load_finished", {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   task automatic make_img(input int n, input bit corrupt);
      logic [7:0] b;
      logic [7:0] x;
      byte_q.delete();
      byte_q.push_back(8'(n));
      if (n >= 1 && n <= 32) begin
         x = 8'(n);
         for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            byte_q.push_back(b);
            x = x ^ b;
         end
         byte_q.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = 16'd0;
         dut_mem[i] = 16'd0;
      end
      rst   = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      bytev = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_state", {ready, pm_we, cpu_ce, busy, done, err, pm_addr, pm_data, wc},
            '0);

      // Known-good image, then corrupted checksum, then recovery from ERR.
      byte_q = '{8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h42};
      run_load(1'b0, 1'b0);
      check("good_done", {29'd0, done, cpu_ce, err}, 32'b110);
      byte_q = '{8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h43};
      run_load(1'b0, 1'b0);
      check("bad_csum_err", {29'd0, done, cpu_ce, err}, 32'b001);
      byte_q = '{8'h02, 8'hA5, 8'hC3, 8'h12, 8'h34, 8'h42};
      run_load(1'b0, 1'b0);

      // Length bounds.
      make_img(0, 1'b0);
      run_load(1'b0, 1'b0);
      make_img(33, 1'b0);
      run_load(1'b0, 1'b0);
      make_img(32, 1'b0);
      run_load(1'b0, 1'b0);
      check("full_image_count", {26'd0, wc}, 32'd32);

      // Randomized loads with gaps, stray starts and occasional corruption.
      for (int k = 0; k < 10; k++) begin
         if (k == 4) make_img($urandom_range(33, 255), 1'b0);
         else make_img($urandom_range(1, 32), $urandom_range(0, 3) == 0);
         run_load(1'b1, k[0]);
      end

      // Reset after the first word's HI byte: no write, everything cleared.
      make_img(2, 1'b0);
      exp_end.push_back('{ok: 1'b0, bad: 1'b0, words: 6'd0});
      pulse_start();
      send(byte_q[0], 1'b0, 1'b0);
      send(byte_q[1], 1'b0, 1'b0);
      valid = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      check("mid_load_reset", {ready, pm_we, cpu_ce, busy, done, err, pm_addr, pm_data, wc},
            '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      make_img($urandom_range(1, 32), 1'b0);
      run_load(1'b1, 1'b0);
      check("fresh_after_reset", {30'd0, done, err}, 32'b10);

      repeat (3) @(negedge clk);
      check("writes_drained", exp_wr.size(), 32'd0);
      check("ends_drained", exp_end.size(), 32'd0);
      for (int i = 0; i < 32; i++) check("mem_contents", {16'd0, dut_mem[i]}, {16'd0, ref_mem[i]});

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
